fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries (power of 2, at least 2).
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port mem_req, output, 1: instruction-memory read request.
REQ-005 SHALL have port mem_addr, output, 30: word address of the request (fetch PC[31:2]).
REQ-006 SHALL have port mem_ack, input, 1: memory has returned mem_data for the current request.
REQ-007 SHALL have port mem_data, input, 32: instruction word, valid only when mem_ack=1.
REQ-008 SHALL have port inst_valid, output, 1: the queue head is presented downstream.
REQ-009 SHALL have port inst_ready, input, 1: the downstream machine accepts the head this cycle.
REQ-010 SHALL have port inst, output, 32: head instruction word.
REQ-011 SHALL have port inst_pc, output, 32: byte PC of the head instruction.
REQ-012 SHALL have port flush, input, 1: redirect fetch and discard all queued instructions.
REQ-013 SHALL have port flush_pc, input, 32: redirect target; bits [1:0] are ignored and treated as 0.
REQ-014 SHALL have port halt, input, 1: stop issuing new requests (driven by the decoder's except).

Function
REQ-015 SHALL implement FSM states FETCH (mem_req=1), WAIT_FULL (mem_req=0), DISCARD (mem_req=1, response dropped) and HALTED (mem_req=0).
REQ-016 SHALL keep at most one request outstanding; once asserted, mem_req and mem_addr SHALL stay stable until the cycle in which mem_ack=1.
REQ-017 SHALL, on mem_ack in FETCH, push {mem_data, fetch_pc} into the queue and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-018 SHALL, in the cycle after an ack, hold mem_req=1 with the next address only if the post-push count is below DEPTH and halt=0; otherwise SHALL enter WAIT_FULL or HALTED respectively.
REQ-019 SHALL leave WAIT_FULL for FETCH in the cycle after a pop makes count < DEPTH, provided halt=0.
REQ-020 SHALL pop on inst_valid & inst_ready; inst_valid SHALL equal (count != 0); inst and inst_pc SHALL be 0 whenever the queue is empty.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-022 SHALL, when an ack lands in an empty queue at edge k, present inst_valid=1 in the cycle following edge k (one-cycle latency).
REQ-023 SHALL, on flush=1, set count to 0 (inst_valid=0 the next cycle) and load fetch_pc with {flush_pc[31:2], 2'b00}; flush SHALL take priority over push and pop in the same cycle.
REQ-024 SHALL, on a flush while a request is outstanding and unacked, enter DISCARD, keep the old address until mem_ack, drop that data, then issue a request at flush_pc.
REQ-025 SHALL, on a flush when no request is outstanding, issue a request at flush_pc in the next cycle, unless halt=1.
REQ-026 SHALL let an outstanding request complete and push while halt=1; the queue SHALL keep draining to downstream.
REQ-027 SHALL resume from HALTED to FETCH in the cycle after halt falls and count < DEPTH.
REQ-028 SHALL never overflow or underflow the queue; a push at count=DEPTH is unreachable by construction (REQ-018).

Reset
REQ-029 SHALL, while reset=1, set fetch_pc=0, count=0, read/write pointers=0 and state=FETCH, with outputs mem_req=0, mem_addr=0, inst_valid=0, inst=0 and inst_pc=0.
REQ-030 SHALL assert mem_req with mem_addr=0 in the first cycle after reset deasserts.
REQ-031 SHALL ignore any mem_ack that arrives while reset=1 or in the first cycle after reset, since no request is then outstanding.
REQ-032 SHALL, on reset asserted mid-request, abandon the outstanding request without pushing its data.

Structure
REQ-033 SHALL place the FSM state encoding and the DEPTH default in shared package fetch_pkg.
REQ-034 SHALL implement queue storage, pointers and count in sub-module fetch_fifo (push, pop, clear, count, head outputs); fetch_queue SHALL hold the FSM and fetch_pc.

Verification
REQ-035 SHALL cover streaming: memory acks every cycle, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC, matching mem_data, with no gaps after the first.
REQ-036 SHALL cover backpressure: inst_ready=0, DEPTH=4 -> exactly 4 acks, then mem_req=0 (WAIT_FULL); one pop -> mem_req=1 next cycle with mem_addr=4.
REQ-037 SHALL cover flush while a request to 0x10 is unacked, flush_pc=0x103 -> 0x10 held until ack, that data is dropped, next mem_addr=0x40 (byte PC 0x100), and the first inst_pc after the flush is 0x100.
REQ-038 SHALL cover flush, pop and ack in the same cycle with count=2 -> count=0 next cycle, and the acked word never appears on inst.
REQ-039 SHALL cover halt=1 while a request is outstanding -> the ack pushes, no new mem_req, the queue drains; halt=0 -> request resumes at the next sequential PC.
REQ-040 SHALL cover reset asserted mid-request with mem_ack in the same cycle -> all outputs 0 next cycle, then mem_req=1 with mem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
// State encoding, queue entry layout and default depth.
package fetch_pkg;

    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT_FULL = 2'd1,
        ST_DISCARD   = 2'd2,
        ST_HALTED    = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {inst, pc} entries.
// Clear wins over push and pop; head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & ((count_q != FULL) | pop_ok);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head  = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request,
// fetched words buffered in order for the decoder.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        halt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [29:0]   disc_addr_q, disc_addr_d;
    logic          armed_q, armed_d;
    logic          req_active, ack_ok;
    logic          push, pop, not_empty;
    logic [CW-1:0] count, post_cnt;
    fetch_entry_t  head, wdata;

    assign req_active = (state_q == ST_FETCH) | (state_q == ST_DISCARD);
    // No request is outstanding until one full cycle after reset.
    assign ack_ok     = mem_ack & req_active & armed_q & ~reset;
    assign not_empty  = (count != '0);
    assign pop        = not_empty & inst_ready & ~reset & ~flush;
    assign push       = ack_ok & (state_q == ST_FETCH) & ~flush;
    assign wdata      = '{inst: mem_data, pc: fetch_pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    always_comb begin
        post_cnt = count;
        if (push & ~pop) post_cnt = count + CW'(1);
        if (pop & ~push) post_cnt = count - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            if (req_active & ~ack_ok) state_d = ST_DISCARD;
            else if (halt)            state_d = ST_HALTED;
            else                      state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (ack_ok) begin
                        if (halt)                  state_d = ST_HALTED;
                        else if (post_cnt == FULL) state_d = ST_WAIT_FULL;
                    end
                end
                ST_WAIT_FULL: begin
                    if (halt)                  state_d = ST_HALTED;
                    else if (post_cnt != FULL) state_d = ST_FETCH;
                end
                ST_DISCARD: begin
                    if (ack_ok) state_d = halt ? ST_HALTED : ST_FETCH;
                end
                ST_HALTED: begin
                    if (~halt & (post_cnt != FULL)) state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        armed_d     = 1'b1;
        if (flush) begin
            fetch_pc_d = flush_pc & ~32'd3;
            // Keep presenting the abandoned address until memory answers it.
            if (state_q == ST_FETCH) disc_addr_d = fetch_pc_q[31:2];
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q  <= '0;
            disc_addr_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        mem_req    = req_active & ~reset;
        mem_addr   = '0;
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        if (~reset) begin
            mem_addr   = (state_q == ST_DISCARD) ? disc_addr_q
                                                 : fetch_pc_q[31:2];
            inst_valid = not_empty;
            inst       = head.inst;
            inst_pc    = head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue with a queue-based scoreboard.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        inst_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] exp_pc;

    always #5 clock = ~clock;

    fetch_queue dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .halt       (halt)
    );

    task automatic tick(input logic rst, input logic ack,
                        input logic [31:0] d, input logic rdy,
                        input logic fl, input logic [31:0] fpc,
                        input logic hl);
        @(posedge clock);
        #1;
        reset      = rst;
        mem_ack    = ack;
        mem_data   = d;
        inst_ready = rdy;
        flush      = fl;
        flush_pc   = fpc;
        halt       = hl;
        @(negedge clock);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 32'h1234_5678, 1, 0, 0, 0);
        n_total++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== '0) begin
            $display("FAIL reset_outputs got req=%b addr=%h v=%b inst=%h pc=%h want all 0",
                     mem_req, mem_addr, inst_valid, inst, inst_pc);
        end else n_pass++;
        tick(0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 30'd0 || inst_valid !== 1'b0) begin
            $display("FAIL reset_release got req=%b addr=%h v=%b want req=1 addr=0 v=0",
                     mem_req, mem_addr, inst_valid);
        end else n_pass++;
        sb.delete();
        exp_pc = 32'd0;
    endtask

    task automatic test_stream();
        logic [31:0] d;
        ent_t        e;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            tick(0, 1, d, 1, 0, 0, 0);
            n_total++;
            if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
                $display("FAIL stream_req got req=%b addr=%h want req=1 addr=%h",
                         mem_req, mem_addr, exp_pc[31:2]);
            end else n_pass++;
            n_total++;
            if (inst_valid !== (sb.size() != 0)) begin
                $display("FAIL stream_valid got %b want %b", inst_valid, sb.size() != 0);
            end else n_pass++;
            if (sb.size() != 0 && inst_ready) begin
                e = sb.pop_front();
                n_total++;
                if (inst !== e.d || inst_pc !== e.pc) begin
                    $display("FAIL stream_head got inst=%h pc=%h want inst=%h pc=%h",
                             inst, inst_pc, e.d, e.pc);
                end else n_pass++;
            end
            sb.push_back('{d, exp_pc});
            exp_pc += 32'd4;
        end
        tick(0, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_total++;
        if (inst_valid !== 1'b1 || inst !== e.d || inst_pc !== e.pc) begin
            $display("FAIL stream_drain got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                     inst_valid, inst, inst_pc, e.d, e.pc);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        exp_req;
        ent_t        e;
        test_reset();
        exp_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = $urandom();
            tick(0, exp_req, d, 0, 0, 0, 0);
            n_total++;
            if (mem_req !== exp_req || (exp_req && mem_addr !== exp_pc[31:2])) begin
                $display("FAIL bp_req cyc=%0d got req=%b addr=%h want req=%b addr=%h",
                         i, mem_req, mem_addr, exp_req, exp_pc[31:2]);
            end else n_pass++;
            n_total++;
            if (inst_valid !== (sb.size() != 0)) begin
                $display("FAIL bp_valid cyc=%0d got %b want %b", i, inst_valid, sb.size() != 0);
            end else n_pass++;
            if (exp_req) begin
                sb.push_back('{d, exp_pc});
                exp_pc += 32'd4;
            end
            exp_req = (sb.size() < 4);
        end
        tick(0, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_total++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== e.d || inst_pc !== e.pc) begin
            $display("FAIL bp_pop got req=%b v=%b inst=%h pc=%h want req=0 v=1 inst=%h pc=%h",
                     mem_req, inst_valid, inst, inst_pc, e.d, e.pc);
        end else n_pass++;
        tick(0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
            $display("FAIL bp_resume got req=%b addr=%h want req=1 addr=%h",
                     mem_req, mem_addr, exp_pc[31:2]);
        end else n_pass++;
    endtask

    task automatic test_flush_discard();
        logic [31:0] d;
        logic [31:0] old_pc;
        ent_t        e;
        test_reset();
        for (int i = 0; i < 4; i++) begin
            d = $urandom();
            tick(0, 1, d, 1, 0, 0, 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_total++;
                if (inst !== e.d || inst_pc !== e.pc) begin
                    $display("FAIL fd_head got inst=%h pc=%h want inst=%h pc=%h",
                             inst, inst_pc, e.d, e.pc);
                end else n_pass++;
            end
            sb.push_back('{d, exp_pc});
            exp_pc += 32'd4;
        end
        tick(0, 0, 0, 0, 1, 32'h0000_0103, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2] || inst_valid !== 1'b1) begin
            $display("FAIL fd_pre got req=%b addr=%h v=%b want req=1 addr=%h v=1",
                     mem_req, mem_addr, inst_valid, exp_pc[31:2]);
        end else n_pass++;
        sb.delete();
        old_pc = exp_pc;
        exp_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick(0, (i == 2), 32'hDEAD_BEEF, 1, 0, 0, 0);
            n_total++;
            if (mem_req !== 1'b1 || mem_addr !== old_pc[31:2] || inst_valid !== 1'b0) begin
                $display("FAIL fd_hold cyc=%0d got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                         i, mem_req, mem_addr, inst_valid, old_pc[31:2]);
            end else n_pass++;
        end
        d = $urandom();
        tick(0, 1, d, 1, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2] || inst_valid !== 1'b0) begin
            $display("FAIL fd_redirect got req=%b addr=%h v=%b want req=1 addr=%h v=0",
                     mem_req, mem_addr, inst_valid, exp_pc[31:2]);
        end else n_pass++;
        sb.push_back('{d, exp_pc});
        exp_pc += 32'd4;
        tick(0, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_total++;
        if (inst_valid !== 1'b1 || inst !== e.d || inst_pc !== e.pc) begin
            $display("FAIL fd_first got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                     inst_valid, inst, inst_pc, e.d, e.pc);
        end else n_pass++;
    endtask

    task automatic test_flush_pop_ack();
        logic [31:0] d;
        ent_t        e;
        test_reset();
        for (int i = 0; i < 2; i++) begin
            d = $urandom();
            tick(0, 1, d, 0, 0, 0, 0);
            sb.push_back('{d, exp_pc});
            exp_pc += 32'd4;
        end
        tick(0, 1, 32'hBADB_AD00, 1, 1, 32'h0000_0200, 0);
        n_total++;
        if (inst_valid !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
            $display("FAIL fpa_pre got v=%b addr=%h want v=1 addr=%h",
                     inst_valid, mem_addr, exp_pc[31:2]);
        end else n_pass++;
        sb.delete();
        exp_pc = 32'h0000_0200;
        tick(0, 0, 0, 1, 0, 0, 0);
        n_total++;
        if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0) begin
            $display("FAIL fpa_empty got v=%b inst=%h pc=%h want v=0 inst=0 pc=0",
                     inst_valid, inst, inst_pc);
        end else n_pass++;
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
            $display("FAIL fpa_req got req=%b addr=%h want req=1 addr=%h",
                     mem_req, mem_addr, exp_pc[31:2]);
        end else n_pass++;
        d = $urandom();
        tick(0, 1, d, 1, 0, 0, 0);
        sb.push_back('{d, exp_pc});
        exp_pc += 32'd4;
        tick(0, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_total++;
        if (inst_valid !== 1'b1 || inst !== e.d || inst_pc !== e.pc) begin
            $display("FAIL fpa_first got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                     inst_valid, inst, inst_pc, e.d, e.pc);
        end else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] d;
        ent_t        e;
        test_reset();
        tick(0, 0, 0, 0, 0, 0, 1);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
            $display("FAIL halt_hold got req=%b addr=%h want req=1 addr=%h",
                     mem_req, mem_addr, exp_pc[31:2]);
        end else n_pass++;
        d = $urandom();
        tick(0, 1, d, 0, 0, 0, 1);
        sb.push_back('{d, exp_pc});
        exp_pc += 32'd4;
        tick(0, 0, 0, 0, 0, 0, 1);
        n_total++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b1) begin
            $display("FAIL halt_stop got req=%b v=%b want req=0 v=1", mem_req, inst_valid);
        end else n_pass++;
        tick(0, 0, 0, 1, 0, 0, 1);
        e = sb.pop_front();
        n_total++;
        if (mem_req !== 1'b0 || inst !== e.d || inst_pc !== e.pc) begin
            $display("FAIL halt_drain got req=%b inst=%h pc=%h want req=0 inst=%h pc=%h",
                     mem_req, inst, inst_pc, e.d, e.pc);
        end else n_pass++;
        tick(0, 0, 0, 1, 0, 0, 1);
        n_total++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            $display("FAIL halt_empty got req=%b v=%b want req=0 v=0", mem_req, inst_valid);
        end else n_pass++;
        tick(0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL halt_fall got req=%b want 0", mem_req);
        end else n_pass++;
        tick(0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
            $display("FAIL halt_resume got req=%b addr=%h want req=1 addr=%h",
                     mem_req, mem_addr, exp_pc[31:2]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        test_reset();
        tick(0, 1, 32'h1111_2222, 0, 0, 0, 0);
        tick(1, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
        n_total++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== '0) begin
            $display("FAIL rmid_during got req=%b addr=%h v=%b inst=%h pc=%h want all 0",
                     mem_req, mem_addr, inst_valid, inst, inst_pc);
        end else n_pass++;
        tick(1, 0, 0, 0, 0, 0, 0);
        n_total++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== '0) begin
            $display("FAIL rmid_after got req=%b addr=%h v=%b inst=%h pc=%h want all 0",
                     mem_req, mem_addr, inst_valid, inst, inst_pc);
        end else n_pass++;
        tick(0, 0, 0, 1, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 30'd0 || inst_valid !== 1'b0) begin
            $display("FAIL rmid_release got req=%b addr=%h v=%b want req=1 addr=0 v=0",
                     mem_req, mem_addr, inst_valid);
        end else n_pass++;
        sb.delete();
        exp_pc = 32'd0;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        ent_t        e;
        test_reset();
        tick(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        exp_pc = 32'hFFFF_FFFC;
        tick(0, 1, 32'h5555_5555, 0, 0, 0, 0);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 30'd0) begin
            $display("FAIL wrap_discard got req=%b addr=%h want req=1 addr=0",
                     mem_req, mem_addr);
        end else n_pass++;
        for (int i = 0; i < 2; i++) begin
            d = $urandom();
            tick(0, 1, d, 0, 0, 0, 0);
            n_total++;
            if (mem_req !== 1'b1 || mem_addr !== exp_pc[31:2]) begin
                $display("FAIL wrap_req cyc=%0d got req=%b addr=%h want req=1 addr=%h",
                         i, mem_req, mem_addr, exp_pc[31:2]);
            end else n_pass++;
            sb.push_back('{d, exp_pc});
            exp_pc += 32'd4;
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1, 0, 0, 0);
            e = sb.pop_front();
            n_total++;
            if (inst_valid !== 1'b1 || inst !== e.d || inst_pc !== e.pc) begin
                $display("FAIL wrap_head cyc=%0d got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                         i, inst_valid, inst, inst_pc, e.d, e.pc);
            end else n_pass++;
        end
    endtask

    initial begin
        exp_pc = 32'd0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_discard();
        test_flush_pop_ack();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
